// File: rtl/edge_pkg.sv
// Shared types and constants for the pixel block reader.
package edge_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH      = 2'd1,
    DONE_PULSE = 2'd2,
    EXHAUSTED  = 2'd3
  } reader_state_t;

  localparam int DEF_PIX_W = 8;

  // Window slot indices: row-major, row 0 at the top, column 0 on the left.
  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

  function automatic logic [3:0] win_idx(input logic [1:0] r, input logic [1:0] c);
    return 4'({2'b00, r} * 4'd3 + {2'b00, c});
  endfunction

endpackage

// File: rtl/pixel_block_reader_if.sv
// Image SRAM read port used by the pixel block reader.
interface pixel_block_reader_if
  import edge_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int PIX_W  = DEF_PIX_W
);
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_ack;
  logic [PIX_W-1:0]  mem_rd_data;

  modport master (output mem_rd_req, output mem_addr, input mem_rd_ack, input mem_rd_data);
  modport slave  (input mem_rd_req, input mem_addr, output mem_rd_ack, output mem_rd_data);
endinterface

// File: rtl/window_shift_reg.sv
// 3x3 pixel window storage with per-slot writes and a one-cycle left shift.
module window_shift_reg
  import edge_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift,
  input  logic [8:0]         wr_en,
  input  logic [PIX_W-1:0]   wr_data,
  output logic [9*PIX_W-1:0] window
);

  logic [PIX_W-1:0] pix [9];

  // Shift drops the left column; the right column keeps stale data until refetched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) pix[i] <= '0;
    end else if (shift) begin
      pix[WIN_TL] <= pix[WIN_TC];
      pix[WIN_TC] <= pix[WIN_TR];
      pix[WIN_ML] <= pix[WIN_MC];
      pix[WIN_MC] <= pix[WIN_MR];
      pix[WIN_BL] <= pix[WIN_BC];
      pix[WIN_BC] <= pix[WIN_BR];
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (wr_en[i]) pix[i] <= wr_data;
      end
    end
  end

  for (genvar g = 0; g < 9; g++) begin : g_out
    assign window[g*PIX_W +: PIX_W] = pix[g];
  end

endmodule

// File: rtl/pixel_block_reader.sv
// Fetches 3x3 neighbourhoods in raster order of window centres.
// Optional replicate-border mode: define PIXEL_READER_BORDER_EN.
module pixel_block_reader
  import edge_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int ADDR_W = 16,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 en_read,
  pixel_block_reader_if.master mem,
  output logic [9*PIX_W-1:0]   window,
  output logic                 read_done,
  output logic                 all_read
);

`ifdef PIXEL_READER_BORDER_EN
  localparam int FIRST_X = 0;
  localparam int LAST_X  = IMG_W - 1;
  localparam int FIRST_Y = 0;
  localparam int LAST_Y  = IMG_H - 1;
`else
  localparam int FIRST_X = 1;
  localparam int LAST_X  = IMG_W - 2;
  localparam int FIRST_Y = 1;
  localparam int LAST_Y  = IMG_H - 2;
`endif
  // One spare bit so cy can step past the last row to mark exhaustion.
  localparam int CW = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1;

  reader_state_t     state_q, state_d;
  logic [CW-1:0]     cx, cy;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        fcol, frow;
  logic              first_col, exhausted, last_fetch, shift;
  logic [8:0]        wr_en;
  int                nx, ny;

  assign first_col  = (cx == CW'(FIRST_X));
  assign exhausted  = (cy > CW'(LAST_Y));
  assign last_fetch = (fcol == 2'd2) && (frow == 2'd2);
  assign read_done  = (state_q == DONE_PULSE);
  assign all_read   = (state_q == EXHAUSTED);

  // Neighbour coordinate of the slot being fetched and its SRAM address.
  always_comb begin
    nx = int'(cx) + int'(fcol) - 1;
    ny = int'(cy) + int'(frow) - 1;
`ifdef PIXEL_READER_BORDER_EN
    if (nx < 0) nx = 0;
    else if (nx > IMG_W - 1) nx = IMG_W - 1;
    if (ny < 0) ny = 0;
    else if (ny > IMG_H - 1) ny = IMG_H - 1;
`endif
    mem.mem_addr = base_q + ADDR_W'(ny * IMG_W + nx);
  end

  // Next-state decode plus request, shift and slot write strobes.
  always_comb begin
    state_d        = state_q;
    shift          = 1'b0;
    wr_en          = '0;
    mem.mem_rd_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!start && en_read) begin
          if (exhausted) begin
            state_d = EXHAUSTED;
          end else begin
            state_d = FETCH;
            shift   = !first_col;
          end
        end
      end
      FETCH: begin
        mem.mem_rd_req = 1'b1;
        if (mem.mem_rd_ack) begin
          wr_en[win_idx(frow, fcol)] = 1'b1;
          if (last_fetch) state_d = DONE_PULSE;
        end
      end
      DONE_PULSE: state_d = IDLE;
      EXHAUSTED:  if (start) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Centre walk, base latch and fetch slot pointer (column-major, top to bottom).
  always_ff @(posedge clk) begin
    if (rst) begin
      cx     <= CW'(FIRST_X);
      cy     <= CW'(FIRST_Y);
      base_q <= '0;
      fcol   <= 2'd0;
      frow   <= 2'd0;
    end else begin
      unique case (state_q)
        IDLE, EXHAUSTED: begin
          if (start) begin
            cx     <= CW'(FIRST_X);
            cy     <= CW'(FIRST_Y);
            base_q <= base_addr;
          end else if (state_q == IDLE && en_read && !exhausted) begin
            fcol <= first_col ? 2'd0 : 2'd2;
            frow <= 2'd0;
          end
        end
        FETCH: begin
          if (mem.mem_rd_ack && !last_fetch) begin
            if (frow == 2'd2) begin
              frow <= 2'd0;
              fcol <= fcol + 2'd1;
            end else begin
              frow <= frow + 2'd1;
            end
          end
        end
        DONE_PULSE: begin
          if (cx == CW'(LAST_X)) begin
            cx <= CW'(FIRST_X);
            cy <= cy + CW'(1);
          end else begin
            cx <= cx + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  window_shift_reg #(.PIX_W(PIX_W)) u_win (
    .clk     (clk),
    .rst     (rst),
    .shift   (shift),
    .wr_en   (wr_en),
    .wr_data (mem.mem_rd_data),
    .window  (window)
  );

endmodule

// File: tb/tb_pixel_block_reader.sv
// Scoreboard bench for pixel_block_reader on a 4x4 image.
module tb_pixel_block_reader;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;
  localparam int AW = 16;
`ifdef PIXEL_READER_BORDER_EN
  localparam bit BORDER = 1'b1;
  localparam logic [9*PW-1:0] EXP_FIRST = 72'h05_04_04_01_00_00_01_00_00;
  localparam int EXP_REQS = 72;
`else
  localparam bit BORDER = 1'b0;
  localparam logic [9*PW-1:0] EXP_FIRST = 72'h0A_09_08_06_05_04_02_01_00;
  localparam int EXP_REQS = 24;
`endif
  localparam int X0 = BORDER ? 0 : 1;
  localparam int X1 = BORDER ? W - 1 : W - 2;
  localparam int Y0 = BORDER ? 0 : 1;
  localparam int Y1 = BORDER ? H - 1 : H - 2;

  logic          clk = 1'b0;
  logic          rst, start, en_read;
  logic [AW-1:0] base_addr;
  logic [9*PW-1:0] window;
  logic          read_done, all_read;

  pixel_block_reader_if #(.ADDR_W(AW), .PIX_W(PW)) mem_bus ();

  pixel_block_reader #(.PIX_W(PW), .ADDR_W(AW), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .en_read   (en_read),
    .mem       (mem_bus),
    .window    (window),
    .read_done (read_done),
    .all_read  (all_read)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [9*PW-1:0] exp_win_q[$];
  logic [AW-1:0]   exp_addr_q[$];
  bit rand_lat  = 1'b0;
  bit saw_wrap  = 1'b0;
  int req_count = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [AW-1:0] pix_addr(input logic [AW-1:0] base, input int x, input int y);
    int xx, yy;
    xx = BORDER ? clampi(x, 0, W - 1) : x;
    yy = BORDER ? clampi(y, 0, H - 1) : y;
    return base + AW'(yy * W + xx);
  endfunction

  // Reference: the window equals the image neighbourhood; fetch order depends on row start.
  function automatic void expect_window(input logic [AW-1:0] base, input int cx, input int cy);
    logic [9*PW-1:0] w;
    logic [AW-1:0]   a;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        a = pix_addr(base, cx + c - 1, cy + r - 1);
        w[(r*3+c)*PW +: PW] = a[PW-1:0];
      end
    end
    exp_win_q.push_back(w);
    if (cx == X0) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++) exp_addr_q.push_back(pix_addr(base, cx + c - 1, cy + r - 1));
    end else begin
      for (int r = 0; r < 3; r++) exp_addr_q.push_back(pix_addr(base, cx + 1, cy + r - 1));
    end
  endfunction

  // Memory model: data = address LSB, optional random wait, address checked on each ack.
  initial begin
    bit busy;
    int wait_n;
    logic [AW-1:0] held;
    busy = 1'b0;
    wait_n = 0;
    held = '0;
    mem_bus.mem_rd_ack  = 1'b0;
    mem_bus.mem_rd_data = '0;
    forever begin
      @(negedge clk);
      mem_bus.mem_rd_ack = 1'b0;
      if (rst || !mem_bus.mem_rd_req) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy   = 1'b1;
          held   = mem_bus.mem_addr;
          wait_n = rand_lat ? int'($urandom_range(1, 5)) : 0;
        end else begin
          check("addr_stable", mem_bus.mem_addr, held);
        end
        if (wait_n == 0) begin
          busy = 1'b0;
          mem_bus.mem_rd_ack  = 1'b1;
          mem_bus.mem_rd_data = mem_bus.mem_addr[PW-1:0];
          req_count++;
          if (mem_bus.mem_addr < 16'h0004) saw_wrap = 1'b1;
          if (exp_addr_q.size() == 0) check("unexpected_req", mem_bus.mem_rd_req, 1'b0);
          else check("addr", mem_bus.mem_addr, exp_addr_q.pop_front());
        end else begin
          wait_n--;
        end
      end
    end
  end

  // Monitor: every read_done pops one expected window.
  initial begin
    forever begin
      @(negedge clk);
      if (read_done) begin
        if (exp_win_q.size() == 0) check("spurious_read_done", read_done, 1'b0);
        else check("window", window, exp_win_q.pop_front());
      end
    end
  end

  task automatic issue(input int cx, input int cy, input logic [AW-1:0] base, input int exp_lat);
    int cyc;
    bit got;
    expect_window(base, cx, cy);
    @(negedge clk);
    en_read = 1'b1;
    cyc = 1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      en_read = 1'b0;
      cyc++;
      if (read_done) got = 1'b1;
    end
    check("read_done_seen", got, 1'b1);
    if (exp_lat > 0) check("latency", cyc, exp_lat);
    check("all_read_low", all_read, 1'b0);
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
    check("all_read_cleared", all_read, 1'b0);
  endtask

  task automatic run_image(input logic [AW-1:0] base, input bit timed, input bit first_chk);
    req_count = 0;
    for (int y = Y0; y <= Y1; y++) begin
      for (int x = X0; x <= X1; x++) begin
        issue(x, y, base, timed ? ((x == X0) ? 11 : 5) : 0);
        if (first_chk && x == X0 && y == Y0) check("first_window", window, EXP_FIRST);
      end
    end
    check("req_count", req_count, EXP_REQS);
    @(negedge clk);
    en_read = 1'b1;
    @(negedge clk);
    en_read = 1'b0;
    check("all_read_rise", all_read, 1'b1);
    check("no_done_on_exhaust", read_done, 1'b0);
    @(negedge clk);
    en_read = 1'b1;
    @(negedge clk);
    en_read = 1'b0;
    repeat (3) @(negedge clk);
    check("all_read_hold", all_read, 1'b1);
    check("no_req_exhausted", mem_bus.mem_rd_req, 1'b0);
  endtask

  initial begin
    bit got;
    rst = 1'b1;
    start = 1'b0;
    en_read = 1'b0;
    base_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_req", mem_bus.mem_rd_req, 1'b0);
    check("rst_done", read_done, 1'b0);
    check("rst_all_read", all_read, 1'b0);
    check("rst_window", window, '0);
    rst = 1'b0;

    do_start(16'h0100);
    run_image(16'h0100, 1'b1, 1'b1);

    rand_lat = 1'b1;
    do_start(16'h0100);
    run_image(16'h0100, 1'b0, 1'b1);

    saw_wrap = 1'b0;
    do_start(16'hFFFE);
    run_image(16'hFFFE, 1'b0, 1'b0);
    check("addr_wrap", saw_wrap, 1'b1);

    // Reset in the middle of a row-start fetch.
    do_start(16'h0100);
    expect_window(16'h0100, X0, Y0);
    @(negedge clk);
    en_read = 1'b1;
    @(negedge clk);
    en_read = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (mem_bus.mem_rd_req) got = 1'b1;
      else @(negedge clk);
    end
    check("req_before_rst", got, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("req_drop_on_rst", mem_bus.mem_rd_req, 1'b0);
    check("window_clear_on_rst", window, '0);
    exp_win_q.delete();
    exp_addr_q.delete();
    rst = 1'b0;
    rand_lat = 1'b0;
    do_start(16'h0100);
    issue(X0, Y0, 16'h0100, 11);
    check("first_window_after_rst", window, EXP_FIRST);
    repeat (3) @(negedge clk);
    check("win_queue_drained", exp_win_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_block_reader.md
# pixel_block_reader

Fetches 3x3 pixel neighbourhoods from the image SRAM for the edge-detection filter, one window per read request from the main controller. Walks window centres in raster order. Refills all 9 pixels at the start of each row and only the new right-hand column (3 pixels) on every other step. Drives the controller's `read_done` / `all_read` inputs and presents the window to the filter.

## Interface
Parameters:
- `PIX_W`, 8, bits per pixel
- `ADDR_W`, 16, SRAM address width
- `IMG_W`, 64, image width in pixels (≥ 3)
- `IMG_H`, 64, image height in pixels (≥ 3)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  pulse: rewind to first window; accepted only in IDLE or EXHAUSTED
- `base_addr`  in  ADDR_W  address of pixel (0,0); sampled on `start`
- `en_read`  in  1  one-cycle pulse: fetch next window
- `mem_rd_req`  out  1  read request; held until acked
- `mem_addr`  out  ADDR_W  read address; stable while `mem_rd_req` is high
- `mem_rd_ack`  in  1  read data valid this cycle
- `mem_rd_data`  in  PIX_W  read data
- `window`  out  9*PIX_W  window; pixel (r,c) at slice index r*3+c, r=0 top, c=0 left
- `read_done`  out  1  one-cycle pulse: `window` valid
- `all_read`  out  1  level: no windows remain

## Operation
- States: IDLE, FETCH, DONE_PULSE, EXHAUSTED.
- Reset: all outputs 0, `window` 0, state IDLE, centre (cx,cy) = first centre.
- IDLE + `en_read`:
  - If no windows remain: go to EXHAUSTED and set `all_read`.
  - Otherwise: go to FETCH. Fetch count is 9 if cx is the first column of a row, else 3.
- FETCH: issues reads one at a time.
  - Full refill order: column-major, left column first, top to bottom within each column.
  - Column refill: shift the window left one column, then fetch the new right column top to bottom.
  - Each `mem_rd_ack` writes `mem_rd_data` into the target slot.
  - When the final ack arrives: go to DONE_PULSE.
- DONE_PULSE: `read_done` = 1 for one cycle. Advance cx; wrap to the first column and increment cy at row end. Return to IDLE.
- EXHAUSTED:
  - `all_read` stays high and `en_read` is ignored.
  - `start` clears `all_read`, rewinds the centre and returns to IDLE.
- Address: `mem_addr = base_addr + y*IMG_W + x`, computed modulo 2^ADDR_W. Wrap-around is not flagged.
- Centre range without border mode: cx 1..IMG_W-2, cy 1..IMG_H-2. That is (IMG_W-2)*(IMG_H-2) windows.
- Any `en_read` arriving outside IDLE/EXHAUSTED is ignored. The controller never issues one.
- `start` outside IDLE/EXHAUSTED is ignored. An outstanding request is never abandoned.
- `rst` mid-FETCH: drops `mem_rd_req` on the same edge. A late ack after reset is ignored.

## Timing
- `en_read` at edge N: `mem_rd_req` high from edge N+1.
- Each fetch takes ≥ 1 cycle:
  - On an ack at edge M, the next request's address is presented from edge M+1.
  - The request stays high with no idle gap.
- Minimum latency from `en_read` to `read_done`:
  - Column step: 5 cycles (3 fetches + DONE_PULSE + issue cycle).
  - Row start: 11 cycles (9 fetches + DONE_PULSE + issue cycle).
- `window` stays stable from `read_done` until the next FETCH writes into it.
- `all_read` rises one cycle after the exhausting `en_read` and does so without `read_done`. The controller then skips filtering and finishes sending.

## Configuration
- `PIXEL_READER_BORDER_EN`
- Defined:
  - Centres cover the whole image: cx 0..IMG_W-1, cy 0..IMG_H-1, giving IMG_W*IMG_H windows.
  - Out-of-range neighbour coordinates are clamped to the edge (replicate border).
  - Clamping is done before address computation.
- Undefined: interior-only centres as above. No clamp logic is present.

## Structure
- Package `edge_pkg`:
  - `reader_state_t` enum.
  - `PIX_W` default.
  - Window index constants (`WIN_TL`…`WIN_BR`).
- Sub-module `window_shift_reg`:
  - 3x3 `PIX_W` register array.
  - Per-slot write enable.
  - Single-cycle left-shift command.
  - Synchronous clear on `rst`.

## Test plan
- IMG_W=IMG_H=4, base 0x0100, border off, zero-latency ack memory holding value = address LSB:
  - 4 `en_read` pulses → 4 `read_done` pulses.
  - First window centre (1,1) = {00,01,02,04,05,06,08,09,0A}.
  - 5th `en_read` → `all_read` = 1, no `read_done`.
- Same setup, count requests: 9+3 for row 1 and 9+3 for row 2, 24 total. Addresses match raster order.
- Ack latency randomised 1–5 cycles: `mem_addr` stable while `mem_rd_req` is high. Windows identical to the zero-latency run.
- Border on, 4x4:
  - 16 windows.
  - Window at (0,0) = {00,00,01,00,00,01,04,04,05}.
  - `all_read` after the 17th `en_read`.
- `rst` asserted mid-FETCH: `mem_rd_req` drops next edge. A following `start` + `en_read` returns the first window again.
- `start` in EXHAUSTED with base 0xFFFE: `all_read` clears, and addresses wrap through 0x0000.
